dual_port_sync_ram: RTL and testbench

True dual-port synchronous RAM with two independent read/write ports, A and B, sharing one clock and one storage array. Each port can write or read any word every cycle. Used as a small register-file or shared buffer between two agents in the same clock domain. Default configuration is 16 words of 8 bits.

---
 rtl/dpram_pkg.sv | 11 +
 rtl/dpram_port.sv | 41 ++++
 rtl/dual_port_sync_ram.sv | 72 +++++++
 tb/tb_dual_port_sync_ram.sv | 139 +++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared constants and types for the dual-port synchronous RAM.
// Holds the default geometry and the word type used by the top and its testbench.
package dpram_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;

    typedef logic [DATA_WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/dpram_port.sv
// One RAM port: gates its write enable with reset and registers the read word.
// Instantiated once per port by dual_port_sync_ram.
module dpram_port
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  wr_en_o,
    output logic [DATA_WIDTH-1:0] dout_o
);

    logic [DATA_WIDTH-1:0] dout_d;
    logic [DATA_WIDTH-1:0] dout_q;

    // A write sampled while reset is asserted is dropped; the read path is read-first.
    always_comb begin
        wr_en_o = 1'b0;
        dout_d  = rd_data_i;
        if (rst_n_i) begin
            wr_en_o = we_i;
        end else begin
            wr_en_o = 1'b0;
        end
    end

    // Output data register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/dual_port_sync_ram.sv
// True dual-port synchronous RAM: shared storage array, two read-first ports,
// and port A priority when both ports write the same word in one cycle.
module dual_port_sync_ram
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Contents start at zero from power-up only; reset deliberately leaves them intact.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic wr_en_a_s;
    logic wr_en_b_s;
    logic wr_b_grant_s;

    dpram_port #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_port_a (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .we_i      (we_a),
        .rd_data_i (mem_q[addr_a]),
        .wr_en_o   (wr_en_a_s),
        .dout_o    (dout_a)
    );

    dpram_port #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_port_b (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .we_i      (we_b),
        .rd_data_i (mem_q[addr_b]),
        .wr_en_o   (wr_en_b_s),
        .dout_o    (dout_b)
    );

    // Port B loses a same-address write collision against port A.
    always_comb begin
        wr_b_grant_s = 1'b0;
        if (wr_en_b_s && !(wr_en_a_s && (addr_a == addr_b))) begin
            wr_b_grant_s = 1'b1;
        end else begin
            wr_b_grant_s = 1'b0;
        end
    end

    // Storage array update; the two enables never target the same word together.
    always_ff @(posedge clk) begin
        if (wr_en_a_s) begin
            mem_q[addr_a] <= din_a;
        end
        if (wr_b_grant_s) begin
            mem_q[addr_b] <= din_b;
        end
    end

endmodule

// File: tb/tb_dual_port_sync_ram.sv
// Self-checking bench for dual_port_sync_ram: directed scenarios followed by
// randomized traffic, all compared against an array-based reference model.
module tb_dual_port_sync_ram;
    import dpram_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       we_a;
    logic [3:0] addr_a;
    word_t      din_a;
    word_t      dout_a;
    logic       we_b;
    logic [3:0] addr_b;
    word_t      din_b;
    word_t      dout_b;

    int    tests;
    int    fails;
    word_t ref_mem [16];
    word_t exp_a;
    word_t exp_b;

    dual_port_sync_ram dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_a   (we_a),
        .addr_a (addr_a),
        .din_a  (din_a),
        .dout_a (dout_a),
        .we_b   (we_b),
        .addr_b (addr_b),
        .din_b  (din_b),
        .dout_b (dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, predict from the model, compare #1 after posedge.
    task automatic step(input string tag, input logic r_n,
                        input logic wa, input logic [3:0] aa, input word_t da,
                        input logic wb, input logic [3:0] ab, input word_t db);
        @(negedge clk);
        rst_n  = r_n;
        we_a   = wa;
        addr_a = aa;
        din_a  = da;
        we_b   = wb;
        addr_b = ab;
        din_b  = db;
        if (!r_n) begin
            exp_a = 8'h00;
            exp_b = 8'h00;
        end else begin
            exp_a = ref_mem[aa];
            exp_b = ref_mem[ab];
            if (wb) ref_mem[ab] = db;
            if (wa) ref_mem[aa] = da;
        end
        @(posedge clk);
        #1;
        check({tag, "_a"}, dout_a, exp_a);
        check({tag, "_b"}, dout_b, exp_b);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        rst_n = 1'b0; we_a = 1'b0; addr_a = 4'd0; din_a = 8'h00;
        we_b = 1'b0; addr_b = 4'd0; din_b = 8'h00;

        // Reset with a write pending on port A: write is dropped, outputs clear.
        step("rst0", 1'b0, 1'b1, 4'd3, 8'hFF, 1'b0, 4'd3, 8'h00);
        step("rst1", 1'b0, 1'b1, 4'd3, 8'hFF, 1'b0, 4'd3, 8'h00);
        step("rst_rd3", 1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 4'd3, 8'h00);
        check("rst_mem3", dout_a, 8'h00);

        // Port A write, then read on both ports.
        step("a_wr", 1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 8'h00);
        step("a_rd", 1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 4'd3, 8'h00);
        check("a_rd_const", dout_a, 8'hA5);
        check("a_rd_xb_const", dout_b, 8'hA5);

        // Port B write, then simultaneous reads.
        step("b_wr", 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 8'h5A);
        step("b_rd", 1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 4'd7, 8'h00);
        check("b_rd_const", dout_b, 8'h5A);

        // Read-first on both ports during a write to the same word.
        step("rfw", 1'b1, 1'b1, 4'd3, 8'h11, 1'b0, 4'd3, 8'h00);
        check("rfw_const", dout_b, 8'hA5);
        step("rfw_nx", 1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 4'd3, 8'h00);
        check("rfw_nx_const", dout_a, 8'h11);

        // Same-address collision: port A wins.
        step("coll", 1'b1, 1'b1, 4'd5, 8'h33, 1'b1, 4'd5, 8'h44);
        step("coll_rd", 1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 4'd5, 8'h00);
        check("coll_const", dout_b, 8'h33);

        // Independent writes at the address extremes.
        step("ind_wr", 1'b1, 1'b1, 4'd0, 8'h0F, 1'b1, 4'd15, 8'hF0);
        step("ind_rd", 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd15, 8'h00);
        check("ind_a_const", dout_a, 8'h0F);
        check("ind_b_const", dout_b, 8'hF0);

        // Mid-operation reset keeps contents.
        step("mid_rst", 1'b0, 1'b1, 4'd0, 8'hEE, 1'b1, 4'd15, 8'hDD);
        step("mid_rd", 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd15, 8'h00);
        check("mid_keep_const", dout_a, 8'h0F);

        // Randomized traffic with a narrow address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            ra = ($urandom % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            rb = ($urandom % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            step("rnd", ($urandom % 16 != 0), 1'($urandom), ra, 8'($urandom),
                 1'($urandom), rb, 8'($urandom));
        end

        // Final sweep of every word through both ports.
        for (int i = 0; i < 16; i++) begin
            step("sweep", 1'b1, 1'b0, 4'(i), 8'h00, 1'b0, 4'(15 - i), 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
